// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM triangular-sum engine, its host sequencer and benches.
`timescale 1ns/1ps
package hlsm_pkg;

  localparam int unsigned HLSM_N_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } hlsm_state_e;

  // Engine latency in cycles from the start strobe to the result window.
  function automatic int unsigned hlsm_latency(input int unsigned n);
    return 2 * n + 2;
  endfunction

  // n(n-1)/2 truncated to the default operand width.
  function automatic logic [HLSM_N_W-1:0] tri_sum(input logic [HLSM_N_W-1:0] n);
    logic [2*HLSM_N_W-1:0] prod;
    prod = (2*HLSM_N_W)'(n) * ((2*HLSM_N_W)'(n) - (2*HLSM_N_W)'(1));
    return HLSM_N_W'(prod >> 1);
  endfunction

endpackage

// File: rtl/hlsm_host_if.sv
// Request, engine and response signals of the HLSM host bundled as one interface.
`timescale 1ns/1ps
interface hlsm_host_if
  import hlsm_pkg::*;
#(
  parameter int unsigned N_W = HLSM_N_W
);

  logic           req_valid;
  logic [N_W-1:0] req_n;
  logic           req_ready;
  logic           hlsm_b;
  logic [N_W-1:0] hlsm_n;
  logic [N_W-1:0] hlsm_result;
  logic           rsp_valid;
  logic [N_W-1:0] rsp_n;
  logic [N_W-1:0] rsp_result;
  logic [N_W-1:0] rsp_expected;
  logic           rsp_mismatch;
  logic           busy;

  // Host side: accepts requests, drives the engine, emits responses.
  modport slave (
    input  req_valid, req_n, hlsm_result,
    output req_ready, hlsm_b, hlsm_n,
    output rsp_valid, rsp_n, rsp_result, rsp_expected, rsp_mismatch, busy
  );

  // Environment side: request source plus the engine result.
  modport master (
    output req_valid, req_n, hlsm_result,
    input  req_ready, hlsm_b, hlsm_n,
    input  rsp_valid, rsp_n, rsp_result, rsp_expected, rsp_mismatch, busy
  );

endinterface

// File: rtl/hlsm_req_fifo.sv
// Show-ahead request FIFO; head is visible on dout whenever empty is low.
`timescale 1ns/1ps
module hlsm_req_fifo
  import hlsm_pkg::*;
#(
  parameter int unsigned WIDTH = HLSM_N_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Qualify strobes with the registered flags and derive next occupancy.
  always_comb begin
    w_do_push   = push & ~r_full;
    w_do_pop    = pop & ~r_empty;
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  // Storage array; contents need no reset since flags gate visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/hlsm_host.sv
// Initiator-side sequencer: queues operands, strobes the HLSM engine, times and
// captures its result, and returns it with a locally computed expected value.
`timescale 1ns/1ps
module hlsm_host
  import hlsm_pkg::*;
#(
  parameter int unsigned N_W        = HLSM_N_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  hlsm_host_if.slave  bus
);

  localparam int unsigned CNT_W  = N_W + 1;
  localparam int unsigned PROD_W = 2 * N_W;

  hlsm_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_hlsm_b;
  logic [N_W-1:0]   r_hlsm_n;
  logic             r_rsp_valid;
  logic [N_W-1:0]   r_rsp_n;
  logic [N_W-1:0]   r_rsp_result;
  logic [N_W-1:0]   r_rsp_expected;
  logic             r_rsp_mismatch;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic [N_W-1:0]   w_head;
  logic [PROD_W-1:0] w_prod;
  logic [N_W-1:0]   w_expected;

  // Full queue refuses pushes even on an edge where the FSM pops.
  assign w_push = bus.req_valid & ~w_full;
  assign w_pop  = (r_state == IDLE) & ~w_empty;

  hlsm_req_fifo #(
    .WIDTH (N_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.req_n),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  // Expected result from the held operand: n*(n-1) in double width, halved, truncated.
  assign w_prod     = PROD_W'(r_hlsm_n) * (PROD_W'(r_hlsm_n) - PROD_W'(1));
  assign w_expected = N_W'(w_prod >> 1);

  // Sequencer: pop, strobe, count down the engine latency, capture, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_hlsm_b       <= 1'b0;
      r_hlsm_n       <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_n        <= '0;
      r_rsp_result   <= '0;
      r_rsp_expected <= '0;
      r_rsp_mismatch <= 1'b0;
    end else begin
      r_hlsm_b    <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_hlsm_n <= w_head;
            r_hlsm_b <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          // 2n+1 cycles until the engine result window.
          r_cnt   <= {r_hlsm_n, 1'b1};
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_n        <= r_hlsm_n;
            r_rsp_result   <= bus.hlsm_result;
            r_rsp_expected <= w_expected;
            r_rsp_mismatch <= (bus.hlsm_result != w_expected);
            r_rsp_valid    <= 1'b1;
            r_state        <= GAP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ~w_full;
  assign bus.hlsm_b       = r_hlsm_b;
  assign bus.hlsm_n       = r_hlsm_n;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_n        = r_rsp_n;
  assign bus.rsp_result   = r_rsp_result;
  assign bus.rsp_expected = r_rsp_expected;
  assign bus.rsp_mismatch = r_rsp_mismatch;
  assign bus.busy         = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_hlsm_host.sv
// Scoreboard bench for hlsm_host with a behavioural HLSM engine model.
`timescale 1ns/1ps
module tb_hlsm_host;
  import hlsm_pkg::*;

  localparam int unsigned NW    = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          MOD   = 1 << NW;

  typedef struct {
    int n;
    int result;
    int expected;
    int mism;
    int cyc;
  } rsp_exp_t;

  typedef struct {
    int n;
    int cyc;
  } start_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   last_r = -1000;
  bit   stub = 1'b0;
  bit   saw_not_ready = 1'b0;

  rsp_exp_t   sb[$];
  start_exp_t sq[$];

  hlsm_host_if #(.N_W(NW)) bus ();

  hlsm_host #(
    .N_W        (NW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int tri_ref(input int n);
    return (n * (n - 1) / 2) % MOD;
  endfunction

  function automatic void check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Engine model: result presented for one cycle, 2n+2 cycles after the strobe.
  int eng_cnt;
  int eng_n;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_cnt <= 0;
      eng_n   <= 0;
    end else if (bus.hlsm_b) begin
      eng_cnt <= 2 * int'(bus.hlsm_n) + 2;
      eng_n   <= int'(bus.hlsm_n);
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign bus.hlsm_result = (eng_cnt == 1) ? NW'(tri_ref(eng_n) + (stub ? 1 : 0)) : '0;

  // Monitor: pops the expected start strobe and response whenever the DUT shows one.
  rsp_exp_t   m_e;
  start_exp_t m_s;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.hlsm_b) begin
        if (sq.size() == 0) check("start_unexpected", 1, 0);
        else begin
          m_s = sq.pop_front();
          check("start_cycle", cyc, m_s.cyc);
          check("start_n", int'(bus.hlsm_n), m_s.n);
        end
      end
      if (bus.rsp_valid) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          m_e = sb.pop_front();
          check("rsp_n", int'(bus.rsp_n), m_e.n);
          check("rsp_result", int'(bus.rsp_result), m_e.result);
          check("rsp_expected", int'(bus.rsp_expected), m_e.expected);
          check("rsp_mismatch", int'(bus.rsp_mismatch), m_e.mism);
          check("rsp_cycle", cyc, m_e.cyc);
        end
      end
    end
  end

  // Offer one request from a falling edge; record expectations at the handshake.
  task automatic send(input int n);
    int waited;
    int a;
    int p;
    int r;
    waited = 0;
    bus.req_valid = 1'b1;
    bus.req_n     = NW'(n);
    while (!bus.req_ready && waited < 200) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check("req_accept_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    p = (a + 1 > last_r + 2) ? a + 1 : last_r + 2;
    r = p + 2 * n + 3;
    last_r = r;
    sq.push_back('{n, p});
    sb.push_back('{n, (tri_ref(n) + (stub ? 1 : 0)) % MOD, tri_ref(n), (stub ? 1 : 0), r});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || sq.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", sb.size() + sq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst_hlsm_b", int'(bus.hlsm_b), 0);
    check("rst_hlsm_n", int'(bus.hlsm_n), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_rsp_n", int'(bus.rsp_n), 0);
    check("rst_rsp_result", int'(bus.rsp_result), 0);
    check("rst_rsp_expected", int'(bus.rsp_expected), 0);
    check("rst_rsp_mismatch", int'(bus.rsp_mismatch), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_req_ready", int'(bus.req_ready), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_n     = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Single request from idle.
    send(2);
    check("busy_active", int'(bus.busy), 1);
    drain();

    // Back-to-back pair, then the degenerate operands.
    send(5);
    send(10);
    drain();
    send(0);
    send(1);
    drain();

    // Saturating burst: queue must fill and stall the source.
    saw_not_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(int'($urandom_range(0, MOD - 1)));
    drain();
    check("ready_deasserted", int'(saw_not_ready), 1);

    // Random operands with random idle gaps.
    for (int i = 0; i < 16; i++) begin
      send(int'($urandom_range(0, MOD - 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Faulty engine: every response must flag a mismatch.
    stub = 1'b1;
    for (int i = 0; i < 4; i++) send(int'($urandom_range(0, MOD - 1)));
    drain();
    stub = 1'b0;

    // Abort in the middle of WAIT, then recover.
    send(7);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sq.delete();
    last_r = -1000;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    send(3);
    drain();

    check("busy_idle", int'(bus.busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
